// File: rtl/fft_pkg.sv
// Shared FFT definitions: default frame geometry, sample field widths and the
// index bit-reversal used by the FFT datapath and its reorder buffer.
package fft_pkg;

    localparam int N         = 16;
    localparam int LOG2N     = 4;
    localparam int DW        = 24;
    localparam int RE_W      = DW / 2;
    localparam int IM_W      = DW - DW / 2;
    localparam int IDX_MAX_W = 10;

    // Reverses the low nbits of idx; bits above nbits come back as zero.
    function automatic logic [IDX_MAX_W-1:0] bitrev(
        input logic [IDX_MAX_W-1:0] idx,
        input int                   nbits
    );
        logic [IDX_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < IDX_MAX_W; i++) begin
            if (i < nbits) begin
                r[i] = idx[nbits - 1 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: synchronous write port, combinational read port.
// Contents are deliberately not reset; bank full flags in the top gate reads.
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = fft_pkg::DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes bit-reversed FFT output at bitrev(index),
// then streams each completed bank out in natural bin order.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N     = fft_pkg::N,
    parameter int LOG2N = fft_pkg::LOG2N,
    parameter int DW    = fft_pkg::DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic          din_sop,
    output logic          din_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_sop,
    output logic          dout_eop,
    output logic          sync_err
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    logic [LOG2N-1:0]     wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0]     rd_cnt_q, rd_cnt_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [1:0]           full_q, full_d;
    logic                 in_frame_q, in_frame_d;
    logic                 sync_err_q, sync_err_d;

    logic                 wr_fire;
    logic                 rd_valid;
    logic                 rd_fire;
    logic                 ram_we;
    logic [LOG2N-1:0]     wr_idx;
    logic [IDX_MAX_W-1:0] wr_rev;
    logic [DW-1:0]        ram_rdata;

    assign din_ready = !full_q[wr_bank_q];
    assign wr_fire   = din_valid & din_ready;
    assign rd_valid  = full_q[rd_bank_q];
    assign rd_fire   = rd_valid & dout_ready;
    assign wr_rev    = bitrev(IDX_MAX_W'(wr_idx), LOG2N);

    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        full_d     = full_q;
        in_frame_d = in_frame_q;
        sync_err_d = 1'b0;
        ram_we     = 1'b0;
        wr_idx     = wr_cnt_q;

        if (wr_fire) begin
            if (din_sop) begin
                // A sop always restarts the bank; one arriving mid-frame flags the lost partial.
                ram_we     = 1'b1;
                wr_idx     = '0;
                wr_cnt_d   = LOG2N'(1);
                in_frame_d = 1'b1;
                sync_err_d = in_frame_q;
            end else if (in_frame_q) begin
                ram_we = 1'b1;
                if (wr_cnt_q == LAST_IDX) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    wr_cnt_d          = '0;
                    in_frame_d        = 1'b0;
                end else begin
                    wr_cnt_d = wr_cnt_q + LOG2N'(1);
                end
            end else begin
                sync_err_d = 1'b1;
            end
        end

        // Reader only touches a full bank and writer only a non-full one, so these never collide.
        if (rd_fire) begin
            if (rd_cnt_q == LAST_IDX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                rd_cnt_d          = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + LOG2N'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= '0;
            in_frame_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            in_frame_q <= in_frame_d;
            sync_err_q <= sync_err_d;
        end
    end

    fft_pingpong_ram #(
        .AW (LOG2N + 1),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({wr_bank_q, wr_rev[LOG2N-1:0]}),
        .wdata (din),
        .raddr ({rd_bank_q, rd_cnt_q}),
        .rdata (ram_rdata)
    );

    assign dout_valid = rd_valid;
    assign dout       = rd_valid ? ram_rdata : '0;
    assign dout_sop   = rd_valid & (rd_cnt_q == '0);
    assign dout_eop   = rd_valid & (rd_cnt_q == LAST_IDX);
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for the bit-reversal reorder buffer (N=16, DW=24).
module tb_fft_bitrev_reorder;

    localparam int N     = 16;
    localparam int LOG2N = 4;
    localparam int DW    = 24;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_sop;
    logic          din_ready;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_sop;
    logic          dout_eop;
    logic          sync_err;

    always #5 clk = ~clk;

    fft_bitrev_reorder #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_sop    (din_sop),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_sop   (dout_sop),
        .dout_eop   (dout_eop),
        .sync_err   (sync_err)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        int            c;
    } out_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   err_pulses = 0;
    int   stall_cycles = 0;
    out_t oq[$];

    // Natural bin k was written at input position rev[k] (hand-computed for N=16).
    int rev [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n && dout_valid && dout_ready) oq.push_back(out_t'{dout, dout_sop, dout_eop, cyc});
        if (sync_err) err_pulses++;
        if (reset_n && din_valid && !din_ready) stall_cycles++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] smp(input int re, input int tag);
        return {12'(re), 12'(tag)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int re, input int tag, input bit sop);
        din       = smp(re, tag);
        din_valid = 1'b1;
        din_sop   = sop;
        for (int w = 0; w < 300 && !din_ready; w++) tick();
        if (!din_ready) chk("send_timeout", 32'(din_ready), 32'd1);
        tick();
        din_valid = 1'b0;
        din_sop   = 1'b0;
    endtask

    task automatic send_frame(input int tag);
        for (int i = 0; i < N; i++) send(i, tag, i == 0);
    endtask

    task automatic wait_outs(input int n);
        for (int w = 0; w < 400 && oq.size() < n; w++) tick();
        chk("out_count", 32'(oq.size()), 32'(n));
    endtask

    task automatic check_frame(input string name, input int tag, input int base);
        for (int k = 0; k < N; k++) begin
            if (base + k < oq.size()) begin
                chk($sformatf("%s_data%0d", name, k), 32'(oq[base+k].d), 32'(smp(rev[k], tag)));
                chk($sformatf("%s_sop%0d", name, k), 32'(oq[base+k].sop), 32'(k == 0));
                chk($sformatf("%s_eop%0d", name, k), 32'(oq[base+k].eop), 32'(k == N - 1));
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        din_sop    = 1'b0;
        dout_ready = 1'b0;

        // Reset
        tick();
        tick();
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_din_ready", 32'(din_ready), 32'd1);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single frame with latency check
        dout_ready = 1'b1;
        oq.delete();
        for (int i = 0; i < N - 1; i++) send(i, 1, i == 0);
        chk("lat_not_yet_valid", 32'(dout_valid), 32'd0);
        send(N - 1, 1, 1'b0);
        chk("lat_valid", 32'(dout_valid), 32'd1);
        chk("lat_first_dout", 32'(dout), 32'(smp(0, 1)));
        chk("lat_first_sop", 32'(dout_sop), 32'd1);
        wait_outs(N);
        check_frame("single", 1, 0);

        // Three back-to-back frames
        tick();
        tick();
        oq.delete();
        stall_cycles = 0;
        for (int f = 0; f < 3; f++) send_frame(2 + f);
        wait_outs(3 * N);
        chk("stream_no_stall", 32'(stall_cycles), 32'd0);
        for (int f = 0; f < 3; f++) check_frame($sformatf("stream_f%0d", f), 2 + f, f * N);
        for (int i = 1; i < oq.size(); i++) begin
            chk($sformatf("stream_contig%0d", i), 32'(oq[i].c - oq[0].c), 32'(i));
        end

        // Backpressure: both banks fill, then drain
        tick();
        tick();
        oq.delete();
        dout_ready = 1'b0;
        send_frame(5);
        chk("bp_ready_after16", 32'(din_ready), 32'd1);
        send_frame(6);
        chk("bp_ready_after32", 32'(din_ready), 32'd0);
        din       = smp(0, 7);
        din_valid = 1'b1;
        din_sop   = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_still_blocked", 32'(din_ready), 32'd0);
        chk("bp_hold_dout", 32'(dout), 32'(smp(0, 5)));
        chk("bp_hold_sop", 32'(dout_sop), 32'd1);
        chk("bp_no_reads", 32'(oq.size()), 32'd0);
        dout_ready = 1'b1;
        for (int i = 0; i < N - 1; i++) tick();
        chk("bp_ready_after15_reads", 32'(din_ready), 32'd0);
        tick();
        chk("bp_ready_after16_reads", 32'(din_ready), 32'd1);
        tick();
        din_valid = 1'b0;
        din_sop   = 1'b0;
        for (int i = 1; i < N; i++) send(i, 7, 1'b0);
        wait_outs(3 * N);
        for (int f = 0; f < 3; f++) check_frame($sformatf("bp_f%0d", f), 5 + f, f * N);
        for (int i = 0; i < 20; i++) tick();
        chk("bp_no_dup", 32'(oq.size()), 32'(3 * N));

        // Early sop at sample 5
        oq.delete();
        err_pulses = 0;
        for (int i = 0; i < 5; i++) send(i, 8, i == 0);
        send_frame(9);
        wait_outs(N);
        for (int i = 0; i < 20; i++) tick();
        chk("early_sop_pulses", 32'(err_pulses), 32'd1);
        chk("early_sop_count", 32'(oq.size()), 32'(N));
        check_frame("early_sop", 9, 0);

        // Valid without sop while idle
        oq.delete();
        err_pulses = 0;
        send(3, 12, 1'b0);
        chk("idle_drop_pulse", 32'(sync_err), 32'd1);
        tick();
        chk("idle_drop_pulse_end", 32'(sync_err), 32'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("idle_drop_pulses", 32'(err_pulses), 32'd1);
        chk("idle_drop_no_out", 32'(oq.size()), 32'd0);
        chk("idle_drop_ready", 32'(din_ready), 32'd1);

        // Reset during readout
        send_frame(10);
        wait_outs(7);
        reset_n = 1'b0;
        tick();
        chk("midrst_valid", 32'(dout_valid), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_ready", 32'(din_ready), 32'd1);
        reset_n = 1'b1;
        oq.delete();
        send_frame(11);
        wait_outs(N);
        for (int i = 0; i < 20; i++) tick();
        chk("midrst_count", 32'(oq.size()), 32'(N));
        check_frame("midrst", 11, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
